// File: rtl/sin_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sine ROM read port between two requesters.
// Optional `SIN_ROM_ARB_COS_EN adds cos0/cos1 inputs that shift the address a quarter period.

module sin_rom_arb_ret #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hit,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= hit;
      if (hit) rdata <= rd_data;
    end
  end
endmodule

module sin_rom_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
`ifdef SIN_ROM_ARB_COS_EN
  input  logic                  cos0,
  input  logic                  cos1,
`endif
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data
);
  localparam int NP = 2;

  logic [NP-1:0]                 req, win, gnt, hit, rvalid;
  logic [NP-1:0][ADDR_WIDTH-1:0] addr;
  logic [NP-1:0][DATA_WIDTH-1:0] rdata;
  logic                          prio;
  logic [ADDR_WIDTH-1:0]         last_addr;
  logic [RD_LAT:1]               vld_pipe, port_pipe;

  assign req = {req1, req0};

`ifdef SIN_ROM_ARB_COS_EN
  localparam logic [ADDR_WIDTH-1:0] QTR = {2'b01, {(ADDR_WIDTH-2){1'b0}}};
  assign addr[0] = cos0 ? addr0 + QTR : addr0;
  assign addr[1] = cos1 ? addr1 + QTR : addr1;
`else
  assign addr = {addr1, addr0};
`endif

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = prio ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

  // Grants are forced off while reset is held so nothing leaves the block mid-reset.
  assign gnt      = rst ? '0 : win;
  assign rom_addr = gnt[1] ? addr[1] : (gnt[0] ? addr[0] : last_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= 1'b0;
      last_addr <= '0;
    end else if (|gnt) begin
      prio      <= gnt[0];
      last_addr <= rom_addr;
    end
  end

  // Tag pipe tracks which port owns the ROM word arriving RD_LAT cycles after a grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      port_pipe <= '0;
    end else begin
      vld_pipe[1]  <= |gnt;
      port_pipe[1] <= gnt[1];
      for (int s = 2; s <= RD_LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        port_pipe[s] <= port_pipe[s-1];
      end
    end
  end

  assign hit = vld_pipe[RD_LAT] ? (port_pipe[RD_LAT] ? 2'b10 : 2'b01) : 2'b00;

  for (genvar i = 0; i < NP; i++) begin : g_ret
    sin_rom_arb_ret #(.DATA_WIDTH(DATA_WIDTH)) u_ret (
      .clk     (clk),
      .rst     (rst),
      .hit     (hit[i]),
      .rd_data (rom_rd_data),
      .rvalid  (rvalid[i]),
      .rdata   (rdata[i])
    );
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign rvalid0 = rvalid[0];
  assign rvalid1 = rvalid[1];
  assign rdata0  = rdata[0];
  assign rdata1  = rdata[1];
endmodule
